// File: rtl/universal_shift_register.sv
// Universal shift register: shifts, rotates, arithmetic right shift, load and clear,
// with a serial-input word counter that pulses word_valid_o on each completed word.
module universal_shift_register #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en_i,
  input  logic [2:0]               mode_i,
  input  logic                     ser_i,
  input  logic [WIDTH-1:0]         load_i,
  output logic [WIDTH-1:0]         sr_o,
  output logic                     ser_o,
  output logic                     word_valid_o,
  output logic [$clog2(WIDTH)-1:0] shift_cnt_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

  localparam logic [2:0] MODE_HOLD  = 3'd0;
  localparam logic [2:0] MODE_SL    = 3'd1;
  localparam logic [2:0] MODE_SR    = 3'd2;
  localparam logic [2:0] MODE_ROL   = 3'd3;
  localparam logic [2:0] MODE_ROR   = 3'd4;
  localparam logic [2:0] MODE_ASR   = 3'd5;
  localparam logic [2:0] MODE_LOAD  = 3'd6;
  localparam logic [2:0] MODE_CLEAR = 3'd7;

  logic [WIDTH-1:0] sr_q, sr_d;
  logic             ser_q, ser_d;
  logic             word_valid_q, word_valid_d;
  logic [CW-1:0]    shift_cnt_q, shift_cnt_d;
  logic             ser_shift;

  always_comb begin
    sr_d         = sr_q;
    ser_d        = ser_q;
    shift_cnt_d  = shift_cnt_q;
    word_valid_d = 1'b0;
    ser_shift    = 1'b0;
    if (en_i) begin
      case (mode_i)
        MODE_SL: begin
          sr_d      = {sr_q[WIDTH-2:0], ser_i};
          ser_d     = sr_q[WIDTH-1];
          ser_shift = 1'b1;
        end
        MODE_SR: begin
          sr_d      = {ser_i, sr_q[WIDTH-1:1]};
          ser_d     = sr_q[0];
          ser_shift = 1'b1;
        end
        MODE_ROL: begin
          sr_d  = {sr_q[WIDTH-2:0], sr_q[WIDTH-1]};
          ser_d = sr_q[WIDTH-1];
        end
        MODE_ROR: begin
          sr_d  = {sr_q[0], sr_q[WIDTH-1:1]};
          ser_d = sr_q[0];
        end
        MODE_ASR: begin
          sr_d  = {sr_q[WIDTH-1], sr_q[WIDTH-1:1]};
          ser_d = sr_q[0];
        end
        MODE_LOAD: begin
          sr_d        = load_i;
          shift_cnt_d = '0;
        end
        MODE_CLEAR: begin
          sr_d        = '0;
          shift_cnt_d = '0;
        end
        default: begin
          sr_d = sr_q;
        end
      endcase
    end
    // Direction is not tracked: SL and SR both advance the same word count.
    if (ser_shift) begin
      if (shift_cnt_q == CNT_MAX) begin
        shift_cnt_d  = '0;
        word_valid_d = 1'b1;
      end else begin
        shift_cnt_d = shift_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q         <= RESET_VAL;
      ser_q        <= 1'b0;
      word_valid_q <= 1'b0;
      shift_cnt_q  <= '0;
    end else begin
      sr_q         <= sr_d;
      ser_q        <= ser_d;
      word_valid_q <= word_valid_d;
      shift_cnt_q  <= shift_cnt_d;
    end
  end

  assign sr_o         = sr_q;
  assign ser_o        = ser_q;
  assign word_valid_o = word_valid_q;
  assign shift_cnt_o  = shift_cnt_q;

endmodule
